// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared types and helpers for the 5-stage pipeline front-end
//           control logic: register index type, the x0 constant, the bundle
//           of stall/flush controls, and the priority decode that turns a
//           redirect/hazard pair into that bundle.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
  } hz_ctrl_t;

  // A resolved redirect outranks a RAW hazard: the stalled instruction is on
  // the wrong path anyway, so the front end must be flushed rather than held.
  function automatic hz_ctrl_t ctrl_decode(input logic redirect, input logic hazard);
    hz_ctrl_t c;
    c = '0;
    if (redirect) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (hazard) begin
      c.pc_stall   = 1'b1;
      c.ifid_stall = 1'b1;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Per-register countdown of pending writes. An entry loaded with
//           WB_LATENCY counts down once per cycle; non-zero means busy.
//           x0 has no entry and always reads idle.
// Ports   : i_clk       clock, rising edge
//           i_rst_n     asynchronous active-low reset
//           i_set_en    load i_set_idx with WB_LATENCY this edge
//           i_set_idx   destination register being issued
//           i_rs1_idx   lookup index 1      -> o_rs1_busy
//           i_rs2_idx   lookup index 2      -> o_rs2_busy
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int WB_LATENCY = 3
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_set_en,
  input  reg_idx_t i_set_idx,
  input  reg_idx_t i_rs1_idx,
  input  reg_idx_t i_rs2_idx,
  output logic     o_rs1_busy,
  output logic     o_rs2_busy
);

  localparam logic [2:0] c_LOAD = 3'(WB_LATENCY);

  // Sized for the full 5-bit index space so lookups never go out of range;
  // entries at or above NUM_REGS are tied idle.
  logic [31:0] w_busy;

  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    if (r < NUM_REGS) begin : g_live
      logic [2:0] cnt_q;
      logic [2:0] cnt_d;

      // Load is evaluated last so a re-issue to a pending register restarts
      // the full latency (youngest writer governs).
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        if (i_set_en && (i_set_idx == 5'(r))) begin
          cnt_d = c_LOAD;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign w_busy[r] = (cnt_q != 3'd0);
    end else begin : g_absent
      assign w_busy[r] = 1'b0;
    end
  end

  assign o_rs1_busy = w_busy[i_rs1_idx];
  assign o_rs2_busy = w_busy[i_rs2_idx];

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module  : hazard_stall_ctrl
// Purpose : Hazard controller for the non-forwarding 5-stage pipeline. Holds
//           PC and IF/ID while an ID source register still has a write in
//           flight, bubbles ID/EX meanwhile, and flushes IF/ID and ID/EX on a
//           redirect resolved in EX. Counts hazard-stall cycles.
// Ports   : i_clk, i_rst_n                clock / async active-low reset
//           i_id_valid                    ID holds a valid instruction
//           i_id_rs1/_rs2, _used          source indices and use flags
//           i_id_rd, i_id_rd_wren         destination and write flag
//           i_ex_redirect                 taken branch/jump in EX
//           o_pc_stall, o_ifid_stall      hold controls
//           o_ifid_flush, o_idex_flush    bubble controls
//           o_stall_cnt                   saturating stall-cycle count
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LATENCY = 3,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_rd_wren,
  input  logic             i_ex_redirect,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic       w_rs1_busy;
  logic       w_rs2_busy;
  logic       w_hazard;
  logic       w_issue;
  logic       w_set_en;
  hz_ctrl_t   w_ctrl;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  hazard_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .WB_LATENCY (WB_LATENCY)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (w_set_en),
    .i_set_idx  (i_id_rd),
    .i_rs1_idx  (i_id_rs1),
    .i_rs2_idx  (i_id_rs2),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy)
  );

  assign w_hazard = i_id_valid &
                    ((i_id_rs1_used & (i_id_rs1 != REG_ZERO) & w_rs1_busy) |
                     (i_id_rs2_used & (i_id_rs2 != REG_ZERO) & w_rs2_busy));

  assign w_issue  = i_id_valid & ~w_hazard & ~i_ex_redirect;
  assign w_set_en = w_issue & i_id_rd_wren & (i_id_rd != REG_ZERO);

  assign w_ctrl       = ctrl_decode(i_ex_redirect, w_hazard);
  assign o_pc_stall   = w_ctrl.pc_stall;
  assign o_ifid_stall = w_ctrl.ifid_stall;
  assign o_ifid_flush = w_ctrl.ifid_flush;
  assign o_idex_flush = w_ctrl.idex_flush;

  // Only cycles lost to a RAW hazard count; a redirect cycle is a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_hazard && !i_ex_redirect && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
